vitals_frame_rx: RTL and testbench

VITALS_FRAME_RX -- requirements
Module: vitals_frame_rx

---
 rtl/vitals_frame_rx.sv | 143 ++++++++++++++
 tb/tb_vitals_frame_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vitals_frame_rx.sv
// vitals_frame_rx
// Receives a serial stream of vital-sign words. The first word after reset
// is the subject age. Every later group of three words forms one frame:
// blood pressure, breath rate, heart beat. A completed frame is presented in
// a registered output slot with a valid/ready handshake.
//
// Optional feature: define FRAME_TIMEOUT_EN to build in a mid-frame watchdog.
// The watchdog drops a partial frame after TIMEOUT consecutive idle cycles
// and pulses timeout_err for one cycle. When the macro is not defined,
// timeout_err is tied to 0 and the receiver waits indefinitely mid-frame.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   in_data      serial sample word (W bits)
//   in_valid     in_data is valid this cycle
//   in_ready     block can accept a word this cycle (combinational)
//   age          header word, captured once per reset
//   age_valid    age has been captured
//   bloodP       blood-pressure sample of the presented frame
//   breathR      breath-rate sample of the presented frame
//   heartB       heart-beat sample of the presented frame
//   frame_valid  bloodP/breathR/heartB hold a complete frame
//   frame_ready  downstream consumes the presented frame
//   frame_cnt    number of frames loaded into the slot, wraps at 256
//   timeout_err  one-cycle pulse when a partial frame is discarded
//
// state | meaning
// S_AGE | waiting for the age header word (only after reset)
// S_BP  | waiting for the blood-pressure word of a frame
// S_BR  | waiting for the breath-rate word
// S_HB  | waiting for the heart-beat word; stalls while the slot is full
module vitals_frame_rx #(
  parameter int W       = 10,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] age,
  output logic         age_valid,
  output logic [W-1:0] bloodP,
  output logic [W-1:0] breathR,
  output logic [W-1:0] heartB,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [7:0]   frame_cnt,
  output logic         timeout_err
);

  localparam logic [1:0] S_AGE = 2'd0;
  localparam logic [1:0] S_BP  = 2'd1;
  localparam logic [1:0] S_BR  = 2'd2;
  localparam logic [1:0] S_HB  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] bp_stg;
  logic [W-1:0] br_stg;
  logic         accept;

  // Only the heart-beat word needs the output slot, so only S_HB stalls.
  assign in_ready = !((state == S_HB) && frame_valid && !frame_ready);
  assign accept   = in_valid && in_ready;

`ifdef FRAME_TIMEOUT_EN
  localparam int IW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_AGE;
      bp_stg      <= '0;
      br_stg      <= '0;
      age         <= '0;
      age_valid   <= 1'b0;
      bloodP      <= '0;
      breathR     <= '0;
      heartB      <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= 8'd0;
`ifdef FRAME_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // Consumption clears the slot; a same-edge load below overrides this.
      if (frame_ready)
        frame_valid <= 1'b0;

      if (accept) begin
        case (state)
          S_AGE: begin
            age       <= in_data;
            age_valid <= 1'b1;
            state     <= S_BP;
          end
          S_BP: begin
            bp_stg <= in_data;
            state  <= S_BR;
          end
          S_BR: begin
            br_stg <= in_data;
            state  <= S_HB;
          end
          default: begin
            bloodP      <= bp_stg;
            breathR     <= br_stg;
            heartB      <= in_data;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
            state       <= S_BP;
          end
        endcase
      end

`ifdef FRAME_TIMEOUT_EN
      timeout_err <= 1'b0;
      if (accept) begin
        idle_cnt <= '0;
      end else if ((state == S_BR || state == S_HB) && in_ready) begin
        // A stalled S_HB (in_ready=0) is back-pressure, not idleness, so it
        // neither counts nor clears. The terminal compare uses TIMEOUT-1 so
        // the drop happens on the edge ending the TIMEOUT-th idle cycle.
        if (idle_cnt == IW'(TIMEOUT - 1)) begin
          state       <= S_BP;
          bp_stg      <= '0;
          br_stg      <= '0;
          idle_cnt    <= '0;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_vitals_frame_rx.sv
module tb_vitals_frame_rx;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] age;
  logic         age_valid;
  logic [W-1:0] bloodP;
  logic [W-1:0] breathR;
  logic [W-1:0] heartB;
  logic         frame_valid;
  logic         frame_ready;
  logic [7:0]   frame_cnt;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  vitals_frame_rx #(.W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .age(age), .age_valid(age_valid),
    .bloodP(bloodP), .breathR(breathR), .heartB(heartB),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         vld;
    logic [W-1:0] d;
    logic         fr;
    logic         ir;
    logic [W-1:0] age;
    logic         av;
    logic [W-1:0] bp;
    logic [W-1:0] br;
    logic [W-1:0] hb;
    logic         fv;
    logic [7:0]   cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, int d, logic fr, logic ir,
                              int a, logic av, int bp, int br, int hb,
                              logic fv, int cnt);
    vec_t x;
    x.rst_n = r; x.vld = v; x.d = W'(d); x.fr = fr; x.ir = ir;
    x.age = W'(a); x.av = av; x.bp = W'(bp); x.br = W'(br); x.hb = W'(hb);
    x.fv = fv; x.cnt = 8'(cnt);
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(logic r, logic v, int d, logic fr);
    rst_n = r; in_valid = v; in_data = W'(d); frame_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(string tag, int bp, int br, int hb, logic fv, int cnt);
    chk({tag, " bloodP"}, 32'(bloodP), 32'(bp));
    chk({tag, " breathR"}, 32'(breathR), 32'(br));
    chk({tag, " heartB"}, 32'(heartB), 32'(hb));
    chk({tag, " frame_valid"}, 32'(frame_valid), 32'(fv));
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(cnt));
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 'h3ff, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; frame_ready = 1'b0;
    #1;
    cyc(1'b0, 1'b1, 'h2aa, 1'b1);
    cyc(1'b0, 1'b1, 'h155, 1'b1);
    chk("reset age", 32'(age), 0);
    chk("reset age_valid", 32'(age_valid), 0);
    chk_frame("reset", 0, 0, 0, 1'b0, 0);
    chk("reset timeout_err", 32'(timeout_err), 0);

    //          rst  v  data   fr ir  age   av bp   br  hb  fv cnt
    // basic frame
    tbl.push_back(mk(1, 1, 'h023, 1, 1, 'h023, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 120,   1, 1, 'h023, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 16,    1, 1, 'h023, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 72,    1, 1, 'h023, 1, 120, 16, 72, 1, 1));
    // back-pressure: frame 1 held, S_HB stalls, release loads frame 2
    tbl.push_back(mk(1, 1, 121,   0, 1, 'h023, 1, 120, 16, 72, 1, 1));
    tbl.push_back(mk(1, 1, 17,    0, 1, 'h023, 1, 120, 16, 72, 1, 1));
    tbl.push_back(mk(1, 1, 73,    0, 0, 'h023, 1, 120, 16, 72, 1, 1));
    tbl.push_back(mk(1, 1, 73,    0, 0, 'h023, 1, 120, 16, 72, 1, 1));
    tbl.push_back(mk(1, 1, 73,    1, 1, 'h023, 1, 121, 17, 73, 1, 2));
    tbl.push_back(mk(1, 0, 0,     1, 1, 'h023, 1, 121, 17, 73, 0, 2));
    tbl.push_back(mk(1, 0, 0,     0, 1, 'h023, 1, 121, 17, 73, 0, 2));
    // age only once: later words are frame words, not age
    tbl.push_back(mk(1, 1, 'h099, 0, 1, 'h023, 1, 121, 17, 73, 0, 2));
    // reset clears everything; in_data ignored during reset
    tbl.push_back(mk(0, 1, 'h3ff, 0, 1, 0,     0, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 'h040, 0, 1, 'h040, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 100,   0, 1, 'h040, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 20,    0, 1, 'h040, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(0, 1, 'h155, 0, 1, 0,     0, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 'h041, 1, 1, 'h041, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 5,     1, 1, 'h041, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 6,     1, 1, 'h041, 1, 0,   0,  0,  0, 0));
    tbl.push_back(mk(1, 1, 7,     0, 1, 'h041, 1, 5,   6,  7,  1, 1));
    // reset discards a held frame
    tbl.push_back(mk(0, 0, 0,     0, 1, 0,     0, 0,   0,  0,  0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      rst_n = tbl[i].rst_n; in_valid = tbl[i].vld;
      in_data = tbl[i].d; frame_ready = tbl[i].fr;
      #1;
      chk({t, " in_ready"}, 32'(in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk({t, " age"}, 32'(age), 32'(tbl[i].age));
      chk({t, " age_valid"}, 32'(age_valid), 32'(tbl[i].av));
      chk_frame(t, int'(tbl[i].bp), int'(tbl[i].br), int'(tbl[i].hb),
                tbl[i].fv, int'(tbl[i].cnt));
      chk({t, " timeout_err"}, 32'(timeout_err), 0);
    end

    // 256 frames: values track input, frame_cnt wraps to 0
    do_reset();
    cyc(1'b1, 1'b1, 'h011, 1'b1);
    for (int i = 0; i < 256; i++) begin
      int bp, br, hb;
      bp = i; br = (i * 3) & 'h3ff; hb = 1023 - i;
      cyc(1'b1, 1'b1, bp, 1'b1);
      cyc(1'b1, 1'b1, br, 1'b1);
      cyc(1'b1, 1'b1, hb, 1'b1);
      chk_frame($sformatf("wrap%0d", i), bp, br, hb, 1'b1, (i + 1) % 256);
    end
    chk("wrap age kept", 32'(age), 'h011);

`ifdef FRAME_TIMEOUT_EN
    // 16 idle cycles in S_BR: one pulse, back to S_BP
    do_reset();
    cyc(1'b1, 1'b1, 'h030, 1'b1);
    cyc(1'b1, 1'b1, 130, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 0, 1'b1);
      chk($sformatf("to idle%0d timeout_err", k), 32'(timeout_err),
          (k == 16) ? 1 : 0);
    end
    cyc(1'b1, 1'b1, 110, 1'b1);
    chk("to pulse width", 32'(timeout_err), 0);
    cyc(1'b1, 1'b1, 18, 1'b1);
    cyc(1'b1, 1'b1, 80, 1'b1);
    chk_frame("to frame", 110, 18, 80, 1'b1, 1);

    // word on idle cycle 16 wins
    do_reset();
    cyc(1'b1, 1'b1, 'h030, 1'b1);
    cyc(1'b1, 1'b1, 130, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b1, 1'b0, 0, 1'b1);
      chk($sformatf("race idle%0d timeout_err", k), 32'(timeout_err), 0);
    end
    cyc(1'b1, 1'b1, 19, 1'b1);
    chk("race accept timeout_err", 32'(timeout_err), 0);
    cyc(1'b1, 1'b1, 81, 1'b1);
    chk("race after timeout_err", 32'(timeout_err), 0);
    chk_frame("race frame", 130, 19, 81, 1'b1, 1);

    // stalled S_HB is not idle
    cyc(1'b1, 1'b1, 200, 1'b0);
    cyc(1'b1, 1'b1, 201, 1'b0);
    for (int k = 0; k < 24; k++) begin
      cyc(1'b1, 1'b1, 202, 1'b0);
      chk($sformatf("stall%0d timeout_err", k), 32'(timeout_err), 0);
    end
    chk_frame("stall held", 130, 19, 81, 1'b1, 1);
    cyc(1'b1, 1'b1, 202, 1'b1);
    chk_frame("stall release", 200, 201, 202, 1'b1, 2);
`else
    // no watchdog: mid-frame wait is indefinite
    do_reset();
    cyc(1'b1, 1'b1, 'h030, 1'b1);
    cyc(1'b1, 1'b1, 130, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b1, 1'b0, 0, 1'b1);
      chk($sformatf("nowd idle%0d timeout_err", k), 32'(timeout_err), 0);
    end
    cyc(1'b1, 1'b1, 18, 1'b1);
    cyc(1'b1, 1'b1, 80, 1'b1);
    chk_frame("nowd frame", 130, 18, 80, 1'b1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
